// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: round-robin owner arbitration for the shared tri-state sysbus
//   clock_i, n_reset_i : rising-edge clock, asynchronous active-low reset
//   req_i[N_REQ]       : level request per bus driver
//   lock_i[N_REQ]      : current owner extends its tenure past HOLD_MAX
//   grant_o[N_REQ]     : registered one-hot (or zero) bus ownership
//   bus_busy_o         : any grant bit high
//   owner_o            : index of granted requester, holds last owner when idle
//   revoked_o          : one-cycle pulse when a tenure ends by timeout
//   ARB_PRIO0_EN       : optional; requester 0 wins every arbitration point
module sysbus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int HOLD_MAX = 4,
  parameter int IDX_W    = $clog2(N_REQ)
) (
  input  logic             clock_i,
  input  logic             n_reset_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] lock_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             bus_busy_o,
  output logic [IDX_W-1:0] owner_o,
  output logic             revoked_o
);
  localparam int TW = $clog2(HOLD_MAX);
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  state_t state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d, req_rr;
  logic [IDX_W-1:0] owner_q, owner_d, rr_q, rr_d, win, idx;
  logic [TW-1:0] ten_q, ten_d;
  logic busy_q, revoked_q, revoked_d, win_v, expire;
  // Scan downward so the last hit is the nearest set bit above rr_q (with wrap).
  always_comb begin
    req_rr = req_i;
`ifdef ARB_PRIO0_EN
    req_rr[0] = 1'b0;
`endif
    win_v = 1'b0;
    win = '0;
    idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(rr_q) + k) % N_REQ);
      if (req_rr[idx]) begin
        win_v = 1'b1;
        win = idx;
      end
    end
`ifdef ARB_PRIO0_EN
    if (req_i[0]) begin
      win_v = 1'b1;
      win = '0;
    end
`endif
  end
  // Timeout only when someone else is waiting and the owner has not locked.
  assign expire = ten_q == TW'(HOLD_MAX - 1) && |(req_i & ~grant_q) && !lock_i[owner_q];
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d = rr_q;
    ten_d = ten_q;
    revoked_d = 1'b0;
    if (state_q == GRANT) begin
      ten_d = (ten_q == TW'(HOLD_MAX - 1)) ? ten_q : ten_q + 1'b1;
      if (!req_i[owner_q] || expire) begin
        grant_d = '0;
        state_d = TURN;
        revoked_d = req_i[owner_q];
      end
    end else if (win_v) begin
      grant_d = N_REQ'(1) << win;
      owner_d = win;
`ifdef ARB_PRIO0_EN
      rr_d = (win == '0) ? rr_q : win;
`else
      rr_d = win;
`endif
      ten_d = '0;
      state_d = GRANT;
    end else begin
      grant_d = '0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q <= IDX_W'(N_REQ - 1);
      ten_q <= '0;
      busy_q <= 1'b0;
      revoked_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      ten_q <= ten_d;
      busy_q <= |grant_d;
      revoked_q <= revoked_d;
    end
  end
  assign grant_o = grant_q;
  assign bus_busy_o = busy_q;
  assign owner_o = owner_q;
  assign revoked_o = revoked_q;
endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb_sysbus_arbiter: vector-table bench for sysbus_arbiter
module tb_sysbus_arbiter;
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] g;
    logic [1:0] o;
    logic       rv;
  } vec_t;
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic [3:0] req = '0, lock = '0, grant;
  logic [1:0] owner;
  logic busy, revoked;
  logic [3:0] prev_g = '0;
  int total = 0, bad = 0, row = 0;
  vec_t tbl[$];
  sysbus_arbiter #(.N_REQ(4), .HOLD_MAX(4)) dut (
    .clock_i(clk), .n_reset_i(n_reset), .req_i(req), .lock_i(lock),
    .grant_o(grant), .bus_busy_o(busy), .owner_o(owner), .revoked_o(revoked)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0h exp=%0h t=%0t", nm, row, act, exp, $time);
    end
  endtask
  task automatic add(input logic rst, input logic [3:0] r, input logic [3:0] l,
                     input logic [3:0] g, input logic [1:0] o, input logic rv);
    tbl.push_back('{rst, r, l, g, o, rv});
  endtask
  task automatic chk_out(input logic [3:0] g, input logic [1:0] o, input logic rv);
    chk("grant", 8'(grant), 8'(g));
    chk("owner", 8'(owner), 8'(o));
    chk("revoked", 8'(revoked), 8'(rv));
    chk("busy", 8'(busy), 8'(|g));
  endtask
  always @(negedge clk) begin
    if (n_reset) begin
      chk("onehot0", 8'($onehot0(grant)), 8'd1);
      chk("busy_or", 8'(busy), 8'(|grant));
      chk("gap", 8'(prev_g != 0 && grant != 0 && prev_g != grant), 8'd0);
      prev_g <= grant;
    end else begin
      prev_g <= '0;
    end
  end
  initial begin
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
`ifdef ARB_PRIO0_EN
    add(0, 4'b1110, 4'b0000, 4'b0010, 1, 0);
    for (int c = 0; c < 3; c++) add(0, 4'b1111, 4'b0000, 4'b0010, 1, 0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 1, 1);
    for (int c = 0; c < 4; c++) add(0, 4'b1111, 4'b0000, 4'b0001, 0, 0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 0, 1);
    add(0, 4'b1111, 4'b0000, 4'b0100, 2, 0);
`else
    for (int c = 0; c < 4; c++) add(0, 4'b0110, 4'b0000, 4'b0010, 1, 0);
    add(0, 4'b0110, 4'b0000, 4'b0000, 1, 1);
    add(0, 4'b0110, 4'b0000, 4'b0100, 2, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2, 0);
    for (int c = 0; c < 20; c++) add(0, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 4; c++) add(0, 4'b1111, 4'b0000, 4'(1 << (p % 4)), 2'(p % 4), 0);
      if (p < 4) add(0, 4'b1111, 4'b0000, 4'b0000, 2'(p), 1);
    end
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0100, 4'b0000, 4'b0100, 2, 0);
    for (int c = 0; c < 10; c++) add(0, 4'b0101, 4'b0100, 4'b0100, 2, 0);
    add(0, 4'b0101, 4'b0000, 4'b0000, 2, 1);
    for (int c = 0; c < 4; c++) add(0, 4'b0101, 4'b0100, 4'b0001, 0, 0);
    add(0, 4'b0101, 4'b0100, 4'b0000, 0, 1);
    add(0, 4'b0101, 4'b0100, 4'b0100, 2, 0);
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      row = i;
      n_reset = !tbl[i].rst;
      req = tbl[i].req;
      lock = tbl[i].lock;
      @(posedge clk);
      #1;
      chk_out(tbl[i].g, tbl[i].o, tbl[i].rv);
    end
    row = 1000;
    n_reset = 1'b0;
    req = '0;
    lock = '0;
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    req = 4'b1000;
    @(posedge clk);
    #1;
    chk_out(4'b1000, 3, 0);
    @(posedge clk);
    #3;
    n_reset = 1'b0;
    #1;
    chk("async_grant", 8'(grant), 8'd0);
    chk("async_busy", 8'(busy), 8'd0);
    chk("async_owner", 8'(owner), 8'd0);
    #1;
    n_reset = 1'b1;
    @(posedge clk);
    #1;
    chk_out(4'b1000, 3, 0);
    req = '0;
    @(posedge clk);
    #1;
    chk_out(4'b0000, 3, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
